rx_byte_fifo: RTL
=================

// Module: rx_byte_fifo
// PURPOSE
//  Receive-side elastic buffer directly downstream of the UART receiver core.
//  Captures each byte-complete strobe (good or errored) as a 9-bit entry {err, data[7:0]}.
//  Presents entries to the host/bus side on a first-word-fall-through valid/ready stream.
//  Reports fill level, full/empty, sticky overflow and a saturating error-byte count.
// PARAMETERS
//  DEPTH     16  entries; power of two, 2..256
//  DROP_ERR  0   1: errored bytes are counted but never stored; 0: stored with err=1
// PORTS
//  clk           in   1        single clock
//  rst           in   1        synchronous, active-high reset
//  rec_data      in   1        1-cycle strobe: good byte on data_rx
//  err_data      in   1        1-cycle strobe: parity/framing error, byte on data_rx
//  data_rx       in   8        received byte, valid in strobe cycle
//  m_valid       out  1        head entry available
//  m_ready       in   1        consumer accepts head when m_valid & m_ready
//  m_data        out  8        head byte
//  m_err         out  1        head byte was received with error
//  fill          out  AW+1     entries held, 0..DEPTH (AW = clog2(DEPTH))
//  full          out  1        fill == DEPTH
//  empty         out  1        fill == 0
//  overflow      out  1        sticky: a byte was lost because buffer was full
//  clr_overflow  in   1        clears overflow
//  err_cnt       out  8        saturating count of err_data strobes
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, fill=0, empty=1, full=0, m_valid=0, overflow=0, err_cnt=0.
//    m_data/m_err = 0 while empty. Reset mid-operation discards all contents; no partial state.
//  - Write event: rec_data | err_data. If both strobes are high in one cycle, err_data wins (entry err=1).
//  - Stored entry: {err_data, data_rx} at wr_ptr; wr_ptr += 1 mod DEPTH (natural AW-bit wrap).
//  - DROP_ERR=1: err_data event → no store, no fill change, err_cnt still increments.
//  - err_cnt: +1 per err_data strobe, saturates at 255, no wrap; cleared only by rst.
//  - Pop: m_valid & m_ready → rd_ptr += 1 mod DEPTH.
//  - FWFT: m_valid = !empty. m_data/m_err are a combinational read of the entry at rd_ptr.
//    A written byte is first visible the cycle after its strobe. No same-cycle bypass when empty.
//  - Full + write, no pop: byte discarded, overflow←1, pointers unchanged.
//  - Full + write + pop same cycle: both accepted, fill stays DEPTH, overflow not set.
//  - Empty + write: fill 0→1 next cycle. m_ready while empty is ignored.
//  - Simultaneous write+pop (not full): fill unchanged, both pointers advance.
//  - fill: registered up/down counter (+write_accepted −pop). full/empty decode from fill.
//  - overflow: set has priority over clr_overflow in the same cycle.
//  - No FSM states beyond pointer/count registers. Every output is a register decode or the memory read; no combinational path from strobe inputs to outputs.
// STRUCTURE
//  - uart_pkg: CLK_RATE, BAUD_RATE and clog2 (existing). Add typedef struct packed {logic err; logic [7:0] data;} rx_entry_t.
//  - Sub-module rx_fifo_mem: DEPTH x rx_entry_t array with synchronous write and asynchronous read (distributed RAM).
//  - Top: pointers, fill counter, flags, err_cnt, DROP_ERR filtering.
// TESTING
//  - After rst, strobe rec_data with data_rx=8'hA5
//    → next cycle m_valid=1, m_data=A5, m_err=0, fill=1.
//    Pulse m_ready → empty=1 next cycle.
//  - Write 8'h00..8'h0F with m_ready=0 (DEPTH=16) → full=1, fill=16.
//    Then write 8'hFF → overflow=1, fill=16.
//    Drain → 00..0F in order, FF never appears.
//  - Full, then rec_data(8'h77) and m_ready in the same cycle
//    → overflow stays 0, fill=16, and 8'h77 is output last.
//  - err_data with 8'h3C, DROP_ERR=0 → entry m_err=1, m_data=3C, err_cnt=1.
//    Same stimulus with DROP_ERR=1 → empty stays 1, err_cnt=1.
//  - 300 err_data strobes → err_cnt=255.
//    clr_overflow asserted in the same cycle as a new overflow → overflow=1.
//  - 40 writes/pops interleaved to cross pointer wrap; assert rst with fill=5
//    → all outputs return to their reset values next cycle.
//    A post-reset write of 8'h11 appears first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, helpers and the receive-buffer entry type.
// Imported by the receive FIFO and its storage array.
package uart_pkg;

  localparam int CLK_RATE  = 50_000_000;
  localparam int BAUD_RATE = 115_200;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Entry storage for the receive FIFO.
// Synchronous write, asynchronous read (distributed RAM).
module rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  rx_entry_t       wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output rx_entry_t       rdata_o
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive-side elastic buffer behind the UART receiver.
// FWFT stream out, fill level, sticky overflow, saturating error count.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rec_data,
  input  logic                     err_data,
  input  logic [7:0]               data_rx,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic                     m_err,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    cnt_q, cnt_d;

  logic      store, pop, wr_ok, lost;
  rx_entry_t wentry, rentry;

  assign full  = (fill_q == (AW+1)'(DEPTH));
  assign empty = (fill_q == '0);

  always_comb begin
    store  = (rec_data | err_data) & ~(DROP_ERR & err_data);
    pop    = ~empty & m_ready;
    wr_ok  = store & (~full | pop);
    lost   = store & full & ~pop;
    wentry = '{err: err_data, data: data_rx};

    wr_d   = wr_ok ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    fill_d = fill_q + (AW+1)'(wr_ok) - (AW+1)'(pop);

    // a new loss beats a clear in the same cycle
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (lost)         ovf_d = 1'b1;

    cnt_d = cnt_q;
    if (err_data && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_q),
    .wdata_i (wentry),
    .raddr_i (rd_q),
    .rdata_o (rentry)
  );

  assign m_valid  = ~empty;
  assign m_data   = empty ? 8'h00 : rentry.data;
  assign m_err    = empty ? 1'b0 : rentry.err;
  assign fill     = fill_q;
  assign overflow = ovf_q;
  assign err_cnt  = cnt_q;

endmodule
